// File: rtl/tmds_pll_pkg.sv
// tmds_pll_pkg: shared types and mode table for the TMDS PLL controller.
// Holds the FSM state enum, the PLLVR divider-select bundle and the mode table.
package tmds_pll_pkg;

  typedef enum logic [2:0] {
    S_RESET,
    S_WAIT_LOCK,
    S_SETTLE,
    S_RUN,
    S_FAULT
  } pll_state_t;

  typedef struct packed {
    logic [5:0] idsel;
    logic [5:0] fbdsel;
    logic [5:0] odsel;
  } pll_div_t;

  localparam int MAX_MODES = 16;

  // Raw PLLVR dynamic codes: each field is the bitwise complement
  // of the static divider value (IDIV_SEL/FBDIV_SEL/ODIV_SEL).
  localparam pll_div_t MODE_TABLE [MAX_MODES] = '{
    // 720p: IDIV 3, FBDIV 54, ODIV 2 -> 371.25 MHz
    0: '{6'd60, 6'd9,  6'd61},
    // 480p: IDIV 0, FBDIV 9, ODIV 2 -> 270 MHz
    1: '{6'd63, 6'd54, 6'd61},
    // IDIV 0, FBDIV 10, ODIV 2 -> 297 MHz
    2: '{6'd63, 6'd53, 6'd61},
    // IDIV 1, FBDIV 10, ODIV 4 -> 148.5 MHz
    3: '{6'd62, 6'd53, 6'd59},
    default: '{6'd60, 6'd9, 6'd61}
  };

  function automatic pll_div_t mode_div(input logic [3:0] m);
    return MODE_TABLE[m];
  endfunction

endpackage

// File: rtl/tmds_lock_filter.sv
// tmds_lock_filter: synchronises PLL LOCK and filters it for qualify/loss.
// Ports: clk, rst_n, lock_async in; qual_en, loss_en enables; lock_ok, lock_lost out.
module tmds_lock_filter #(
  parameter int LOCK_FILT = 64,
  parameter int LOSS_FILT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic lock_async,
  input  logic qual_en,
  input  logic loss_en,
  output logic lock_ok,
  output logic lock_lost
);

  localparam int QW = $clog2(LOCK_FILT + 1);
  localparam int LW = $clog2(LOSS_FILT + 1);

  logic [1:0]    sync;
  logic          synced;
  logic [QW-1:0] qual_cnt;
  logic [LW-1:0] loss_cnt;

  assign synced = sync[1];

  // Asserted on the cycle that completes the required run of samples.
  assign lock_ok = qual_en && synced &&
                   (qual_cnt == QW'(LOCK_FILT - 1));
  assign lock_lost = loss_en && !synced &&
                     (loss_cnt == LW'(LOSS_FILT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync     <= '0;
      qual_cnt <= '0;
      loss_cnt <= '0;
    end else begin
      sync <= {sync[0], lock_async};
      if (!qual_en || !synced) begin
        qual_cnt <= '0;
      end else if (!lock_ok) begin
        qual_cnt <= qual_cnt + QW'(1);
      end
      if (!loss_en || synced) begin
        loss_cnt <= '0;
      end else if (!lock_lost) begin
        loss_cnt <= loss_cnt + LW'(1);
      end
    end
  end

endmodule

// File: rtl/tmds_pll_mode_ctrl.sv
// tmds_pll_mode_ctrl: PLLVR dynamic-divider mode controller with lock sequencing.
// Ports: clkin, rst_n, mode_sel/mode_req in; mode_ack/mode_err, cur_mode out;
//   pll_lock in; pll_reset, pll_idsel/fbdsel/odsel, pix_rst_n out;
//   locked/busy/fault status; loss_cnt/retry_cnt live only with PLL_STATS_EN.
import tmds_pll_pkg::*;

module tmds_pll_mode_ctrl #(
  parameter int NUM_MODES    = 4,
  parameter int MODE_W       = 2,
  parameter int DEFAULT_MODE = 0,
  parameter int RST_HOLD     = 16,
  parameter int LOCK_FILT    = 64,
  parameter int LOCK_TIMEOUT = 27000,
  parameter int LOSS_FILT    = 4,
  parameter int PIX_RST_DLY  = 256,
  parameter int MAX_RETRY    = 3
) (
  input  logic              clkin,
  input  logic              rst_n,
  input  logic [MODE_W-1:0] mode_sel,
  input  logic              mode_req,
  output logic              mode_ack,
  output logic              mode_err,
  output logic [MODE_W-1:0] cur_mode,
  input  logic              pll_lock,
  output logic              pll_reset,
  output logic [5:0]        pll_idsel,
  output logic [5:0]        pll_fbdsel,
  output logic [5:0]        pll_odsel,
  output logic              pix_rst_n,
  output logic              locked,
  output logic              busy,
  output logic              fault,
  output logic [7:0]        loss_cnt,
  output logic [7:0]        retry_cnt
);

  localparam int MAX_A   = (RST_HOLD > PIX_RST_DLY) ? RST_HOLD : PIX_RST_DLY;
  localparam int CNT_MAX = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int RW      = $clog2(MAX_RETRY + 1);

  pll_state_t    state;
  logic [CW-1:0] cnt;
  logic [RW-1:0] retries;
  pll_div_t      div;

  logic qual_en;
  logic loss_en;
  logic lock_ok;
  logic lock_lost;
  logic accept;
  logic timeout;
  logic fail_ev;
  logic run_loss;

  assign pll_idsel  = div.idsel;
  assign pll_fbdsel = div.fbdsel;
  assign pll_odsel  = div.odsel;

  assign qual_en = (state == S_WAIT_LOCK);
  assign loss_en = (state == S_SETTLE) || (state == S_RUN);

  assign accept = mode_req &&
                  ((state == S_RUN) || (state == S_FAULT)) &&
                  ({1'b0, mode_sel} < (MODE_W + 1)'(NUM_MODES));

  assign timeout = (state == S_WAIT_LOCK) && !lock_ok &&
                   (cnt == CW'(LOCK_TIMEOUT - 1));

  // A failed attempt: qualification timed out or lock dropped while settling.
  assign fail_ev  = timeout || ((state == S_SETTLE) && lock_lost);
  assign run_loss = (state == S_RUN) && lock_lost && !accept;

  tmds_lock_filter #(
    .LOCK_FILT(LOCK_FILT),
    .LOSS_FILT(LOSS_FILT)
  ) u_filt (
    .clk       (clkin),
    .rst_n     (rst_n),
    .lock_async(pll_lock),
    .qual_en   (qual_en),
    .loss_en   (loss_en),
    .lock_ok   (lock_ok),
    .lock_lost (lock_lost)
  );

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RESET;
      cnt       <= '0;
      retries   <= '0;
      div       <= mode_div(4'(DEFAULT_MODE));
      cur_mode  <= MODE_W'(DEFAULT_MODE);
      pll_reset <= 1'b1;
      pix_rst_n <= 1'b0;
      locked    <= 1'b0;
      busy      <= 1'b1;
      fault     <= 1'b0;
      mode_ack  <= 1'b0;
      mode_err  <= 1'b0;
    end else begin
      mode_ack <= 1'b0;
      mode_err <= mode_req && !accept;
      if (accept) begin
        // New dividers land together with pll_reset rising.
        mode_ack  <= 1'b1;
        cur_mode  <= mode_sel;
        div       <= mode_div(4'(mode_sel));
        retries   <= '0;
        state     <= S_RESET;
        cnt       <= '0;
        pll_reset <= 1'b1;
        pix_rst_n <= 1'b0;
        locked    <= 1'b0;
        busy      <= 1'b1;
        fault     <= 1'b0;
      end else if (fail_ev) begin
        retries   <= retries + RW'(1);
        cnt       <= '0;
        pll_reset <= 1'b1;
        if (retries == RW'(MAX_RETRY - 1)) begin
          state <= S_FAULT;
          busy  <= 1'b0;
          fault <= 1'b1;
        end else begin
          state <= S_RESET;
        end
      end else if (run_loss) begin
        state     <= S_RESET;
        cnt       <= '0;
        pll_reset <= 1'b1;
        pix_rst_n <= 1'b0;
        locked    <= 1'b0;
        busy      <= 1'b1;
      end else begin
        unique case (state)
          S_RESET: begin
            if (cnt == CW'(RST_HOLD - 1)) begin
              state     <= S_WAIT_LOCK;
              cnt       <= '0;
              pll_reset <= 1'b0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          S_WAIT_LOCK: begin
            if (lock_ok) begin
              state <= S_SETTLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          S_SETTLE: begin
            if (cnt == CW'(PIX_RST_DLY - 1)) begin
              state     <= S_RUN;
              pix_rst_n <= 1'b1;
              locked    <= 1'b1;
              busy      <= 1'b0;
              retries   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          S_RUN: begin
          end
          S_FAULT: begin
          end
          default: begin
            state <= S_RESET;
          end
        endcase
      end
    end
  end

`ifdef PLL_STATS_EN
  logic [7:0] loss_q;
  logic [7:0] retry_q;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      loss_q  <= '0;
      retry_q <= '0;
    end else begin
      if (run_loss && (loss_q != 8'hFF)) begin
        loss_q <= loss_q + 8'd1;
      end
      if (fail_ev && (retry_q != 8'hFF)) begin
        retry_q <= retry_q + 8'd1;
      end
    end
  end

  assign loss_cnt  = loss_q;
  assign retry_cnt = retry_q;
`else
  assign loss_cnt  = 8'd0;
  assign retry_cnt = 8'd0;
`endif

endmodule
